// File: rtl/rr_group_arbiter_if.sv
// Handshake/bus bundle for rr_group_arbiter.
//   slave  : arbiter side. It takes enable/requests/ready and drives the grant, address, ack and group status.
//   master : requester/downstream side. It drives enable/requests/ready and observes the rest.
interface rr_group_arbiter_if #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = $clog2(WIDTH)
);
   logic              enable_i;
   logic [WIDTH-1:0]  req_i;
   logic [WIDTH-1:0]  gnt_o;
   logic [ADDR_W-1:0] addr_o;
   logic              gnt_valid_o;
   logic              gnt_ready_i;
   logic [WIDTH-1:0]  ack_o;
   logic              grp_release_o;
   logic [ADDR_W:0]   grp_cnt_o;

   modport master (
      output enable_i, req_i, gnt_ready_i,
      input  gnt_o, addr_o, gnt_valid_o, ack_o, grp_release_o, grp_cnt_o
   );

   modport slave (
      input  enable_i, req_i, gnt_ready_i,
      output gnt_o, addr_o, gnt_valid_o, ack_o, grp_release_o, grp_cnt_o
   );
endinterface

// File: rtl/rr_group_arbiter.sv
// Round-robin group arbiter for event-pixel readout.
// Lines are granted in ascending index order within a group pass. The grant is registered and one-hot, and a
// binary address goes with it. Both are held under a valid/ready handshake. When a pass completes, a release
// pulse is produced. A per-line ack tells the pixel that its request was taken.
//
// Ports
//   clk_i    : clock, rising edge
//   reset_i  : asynchronous, active-high reset
//   bus      : rr_group_arbiter_if.slave, which carries:
//      enable_i       arbitration enable; low clears synchronously to idle
//      req_i          level requests, bit i = line i
//      gnt_o/addr_o   registered one-hot grant and its binary index (0 when not valid)
//      gnt_valid_o    grant valid
//      gnt_ready_i    downstream accepts the current grant
//      ack_o          combinational, gnt_o while the handshake fires
//      grp_release_o  one-cycle pulse after the last grant of a pass is accepted
//      grp_cnt_o      grants accepted in the current pass
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no grant outstanding; waits for any request
// ST_GRANT| grant registered and held until the handshake or a disable
module rr_group_arbiter #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = $clog2(WIDTH)
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   rr_group_arbiter_if.slave    bus
);

   typedef enum logic {ST_IDLE, ST_GRANT} state_t;

   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [ADDR_W:0]  CNT_MAX  = (ADDR_W+1)'(WIDTH);
   localparam logic [ADDR_W:0]  CNT_ONE  = (ADDR_W+1)'(1);

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  gnt_q, gnt_d;
   logic [WIDTH-1:0]  mask_q, mask_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              release_q, release_d;

   logic              hs;
   logic              last;
   logic              wrap;
   logic [WIDTH-1:0]  nxt_mask;
   logic [WIDTH-1:0]  base_set;
   logic [WIDTH-1:0]  sel_mask;
   logic [WIDTH-1:0]  mreq;
   logic [WIDTH-1:0]  cand;
   logic [WIDTH-1:0]  cand_oh;
   logic [ADDR_W-1:0] cand_idx;

   assign hs = (state_q == ST_GRANT) & bus.gnt_ready_i & bus.enable_i;

   // Lines strictly above the current grant. This mask is empty when the top line holds the grant.
   always_comb begin
      nxt_mask = '0;
      for (int i = 0; i < WIDTH; i++) begin
         nxt_mask[i] = (i > int'(addr_q));
      end
   end

   assign last = (bus.req_i & nxt_mask & ~gnt_q) == '0;

   // When a grant is accepted, that line is excluded from the same-cycle pick.
   // If the pass just ended, the search restarts from the bottom.
   assign base_set = hs ? (bus.req_i & ~gnt_q) : bus.req_i;
   assign sel_mask = hs ? (last ? ALL_ONES : nxt_mask) : mask_q;
   assign mreq     = base_set & sel_mask;
   assign wrap     = (mreq == '0) && (base_set != '0);
   assign cand     = wrap ? base_set : mreq;
   assign cand_oh  = cand & (~cand + WIDTH'(1));

   always_comb begin
      cand_idx = '0;
      for (int i = WIDTH-1; i >= 0; i--) begin
         if (cand[i]) cand_idx = ADDR_W'(i);
      end
   end

   // The count shows the full pass total during the release cycle and is cleared after that cycle.
   // A grant that is accepted during the release cycle therefore counts as the first grant of the new pass.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      addr_d    = addr_q;
      mask_d    = mask_q;
      cnt_d     = release_q ? '0 : cnt_q;
      release_d = 1'b0;

      if (!bus.enable_i) begin
         state_d = ST_IDLE;
         gnt_d   = '0;
         addr_d  = '0;
         mask_d  = ALL_ONES;
         cnt_d   = '0;
      end else begin
         if (hs) begin
            if (cnt_d != CNT_MAX) cnt_d = cnt_d + CNT_ONE;
            if (last) begin
               mask_d    = ALL_ONES;
               release_d = 1'b1;
            end else begin
               mask_d    = nxt_mask;
            end
         end
         if ((state_q == ST_IDLE) || hs) begin
            if (cand != '0) begin
               state_d = ST_GRANT;
               gnt_d   = cand_oh;
               addr_d  = cand_idx;
               // A fallback pick starts a new pass without a release pulse.
               if (wrap) begin
                  mask_d = ALL_ONES;
                  cnt_d  = '0;
               end
            end else begin
               state_d = ST_IDLE;
               gnt_d   = '0;
               addr_d  = '0;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         gnt_q     <= '0;
         addr_q    <= '0;
         mask_q    <= ALL_ONES;
         cnt_q     <= '0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         addr_q    <= addr_d;
         mask_q    <= mask_d;
         cnt_q     <= cnt_d;
         release_q <= release_d;
      end
   end

   assign bus.gnt_o         = gnt_q;
   assign bus.addr_o        = addr_q;
   assign bus.gnt_valid_o   = (state_q == ST_GRANT);
   assign bus.ack_o         = hs ? gnt_q : '0;
   assign bus.grp_release_o = release_q;
   assign bus.grp_cnt_o     = cnt_q;

endmodule

// File: tb/tb_rr_group_arbiter.sv
// Scoreboard bench for rr_group_arbiter. It uses a WIDTH=8 instance and a WIDTH=16 instance.
// The reference model tracks the pass position as the integer index of the last accepted line.
module tb_rr_group_arbiter;

   logic clk_i = 1'b0;
   logic rst8  = 1'b1;
   logic rst16 = 1'b1;

   always #5 clk_i = ~clk_i;

   rr_group_arbiter_if #(.WIDTH(8))  bus8 ();
   rr_group_arbiter_if #(.WIDTH(16)) bus16 ();

   rr_group_arbiter #(.WIDTH(8)) dut8 (
      .clk_i   (clk_i),
      .reset_i (rst8),
      .bus     (bus8.slave)
   );

   rr_group_arbiter #(.WIDTH(16)) dut16 (
      .clk_i   (clk_i),
      .reset_i (rst16),
      .bus     (bus16.slave)
   );

   typedef struct {
      bit valid;
      int idx;
      int pos;
      int cnt;
      bit rel;
   } mstate_t;

   typedef struct {
      logic [15:0] gnt;
      logic [15:0] addr;
      logic [15:0] ack;
      logic [15:0] cnt;
      logic        valid;
      logic        rel;
   } exp_t;

   exp_t    q8[$];
   exp_t    q16[$];
   mstate_t m8, m16;
   int      vectors = 0;
   int      miscompares = 0;

   function automatic mstate_t reset_state();
      mstate_t s;
      s.valid = 1'b0;
      s.idx   = 0;
      s.pos   = -1;
      s.cnt   = 0;
      s.rel   = 1'b0;
      return s;
   endfunction

   // Returns the lowest requested line above 'from' that is not 'excl', or -1 if there is none.
   function automatic int lowest_above(logic [15:0] req, int from, int excl, int w);
      for (int i = from + 1; i < w; i++) begin
         if (req[i] && i != excl) return i;
      end
      return -1;
   endfunction

   function automatic mstate_t step(mstate_t s, bit en, logic [15:0] req, bit rdy, int w);
      mstate_t n;
      int k;
      int c;
      n     = s;
      n.rel = 1'b0;
      n.cnt = s.rel ? 0 : s.cnt;
      if (!en) return reset_state();
      if (!s.valid) begin
         c = lowest_above(req, s.pos, -1, w);
         if (c < 0) begin
            c = lowest_above(req, -1, -1, w);
            if (c >= 0) begin
               n.pos = -1;
               n.cnt = 0;
            end
         end
         if (c >= 0) begin
            n.valid = 1'b1;
            n.idx   = c;
         end
      end else if (rdy) begin
         k     = s.idx;
         n.cnt = (n.cnt < w) ? n.cnt + 1 : w;
         n.pos = k;
         c     = lowest_above(req, k, -1, w);
         if (c < 0) begin
            n.rel = 1'b1;
            n.pos = -1;
            c     = lowest_above(req, -1, k, w);
         end
         if (c >= 0) begin
            n.idx = c;
         end else begin
            n.valid = 1'b0;
            n.idx   = 0;
         end
      end
      return n;
   endfunction

   function automatic exp_t expect_of(mstate_t s, bit en, bit rdy);
      exp_t e;
      e.valid = s.valid;
      e.gnt   = s.valid ? (16'(1) << s.idx) : 16'(0);
      e.addr  = s.valid ? 16'(s.idx) : 16'(0);
      e.cnt   = 16'(s.cnt);
      e.rel   = s.rel;
      e.ack   = (s.valid && en && rdy) ? e.gnt : 16'(0);
      return e;
   endfunction

   // Drives one cycle's inputs just after the rising edge and records the outputs expected until the next edge.
   task automatic drive(bit r8, bit en8, logic [7:0] req8, bit rdy8,
                        bit r16, bit en16, logic [15:0] req16, bit rdy16);
      @(posedge clk_i);
      #1;
      rst8               = r8;
      bus8.enable_i      = en8;
      bus8.req_i         = req8;
      bus8.gnt_ready_i   = rdy8;
      rst16              = r16;
      bus16.enable_i     = en16;
      bus16.req_i        = req16;
      bus16.gnt_ready_i  = rdy16;
      if (r8)  m8  = reset_state();
      if (r16) m16 = reset_state();
      q8.push_back(expect_of(m8, en8, rdy8));
      q16.push_back(expect_of(m16, en16, rdy16));
      m8  = r8  ? reset_state() : step(m8,  en8,  {8'h00, req8}, rdy8, 8);
      m16 = r16 ? reset_state() : step(m16, en16, req16, rdy16, 16);
   endtask

   task automatic d8(bit r, bit en, logic [7:0] req, bit rdy);
      drive(r, en, req, rdy, 1'b0, 1'b0, 16'h0000, 1'b0);
   endtask

   task automatic check(string tag, exp_t e, logic [15:0] gnt, logic [15:0] addr, logic valid,
                        logic [15:0] ack, logic rel, logic [15:0] cnt);
      vectors++;
      if (gnt !== e.gnt) begin
         miscompares++;
         $display("FAIL %s gnt_o: got %h expected %h at %0t", tag, gnt, e.gnt, $time);
      end
      if (addr !== e.addr) begin
         miscompares++;
         $display("FAIL %s addr_o: got %0d expected %0d at %0t", tag, addr, e.addr, $time);
      end
      if (valid !== e.valid) begin
         miscompares++;
         $display("FAIL %s gnt_valid_o: got %b expected %b at %0t", tag, valid, e.valid, $time);
      end
      if (ack !== e.ack) begin
         miscompares++;
         $display("FAIL %s ack_o: got %h expected %h at %0t", tag, ack, e.ack, $time);
      end
      if (rel !== e.rel) begin
         miscompares++;
         $display("FAIL %s grp_release_o: got %b expected %b at %0t", tag, rel, e.rel, $time);
      end
      if (cnt !== e.cnt) begin
         miscompares++;
         $display("FAIL %s grp_cnt_o: got %0d expected %0d at %0t", tag, cnt, e.cnt, $time);
      end
   endtask

   // Monitor: compares each instance's outputs against the oldest pending expectation.
   initial begin
      forever begin
         @(negedge clk_i);
         if (q8.size() > 0) begin
            check("w8", q8.pop_front(), {8'h00, bus8.gnt_o}, 16'(bus8.addr_o), bus8.gnt_valid_o,
                  {8'h00, bus8.ack_o}, bus8.grp_release_o, 16'(bus8.grp_cnt_o));
         end
         if (q16.size() > 0) begin
            check("w16", q16.pop_front(), bus16.gnt_o, 16'(bus16.addr_o), bus16.gnt_valid_o,
                  bus16.ack_o, bus16.grp_release_o, 16'(bus16.grp_cnt_o));
         end
      end
   end

   initial begin
      bus8.enable_i     = 1'b0;
      bus8.req_i        = '0;
      bus8.gnt_ready_i  = 1'b0;
      bus16.enable_i    = 1'b0;
      bus16.req_i       = '0;
      bus16.gnt_ready_i = 1'b0;
      m8  = reset_state();
      m16 = reset_state();
      repeat (3) @(posedge clk_i);

      // Reset state, then idle with enable high.
      d8(1'b0, 1'b0, 8'h00, 1'b0);
      d8(1'b0, 1'b1, 8'h00, 1'b1);
      d8(1'b0, 1'b1, 8'h00, 1'b1);

      // Two sparse requests in a single pass.
      d8(1'b0, 1'b1, 8'h0A, 1'b1);
      d8(1'b0, 1'b1, 8'h0A, 1'b1);
      d8(1'b0, 1'b1, 8'h08, 1'b1);
      d8(1'b0, 1'b1, 8'h00, 1'b1);
      d8(1'b0, 1'b1, 8'h00, 1'b1);

      // Backpressure on idx4 while a lower request arrives.
      d8(1'b0, 1'b1, 8'h10, 1'b0);
      d8(1'b0, 1'b1, 8'h10, 1'b0);
      repeat (5) d8(1'b0, 1'b1, 8'h11, 1'b0);
      d8(1'b0, 1'b1, 8'h11, 1'b1);
      d8(1'b0, 1'b1, 8'h01, 1'b1);
      d8(1'b0, 1'b1, 8'h00, 1'b1);
      d8(1'b0, 1'b1, 8'h00, 1'b1);

      // Late low request during a pass at idx5/6.
      d8(1'b0, 1'b1, 8'h60, 1'b0);
      d8(1'b0, 1'b1, 8'h64, 1'b1);
      d8(1'b0, 1'b1, 8'h24, 1'b1);
      d8(1'b0, 1'b1, 8'h04, 1'b1);
      d8(1'b0, 1'b1, 8'h00, 1'b1);
      d8(1'b0, 1'b1, 8'h00, 1'b1);

      // Enable drop with a grant pending, then re-enable with the top line requesting.
      d8(1'b0, 1'b1, 8'h08, 1'b0);
      d8(1'b0, 1'b1, 8'h08, 1'b0);
      d8(1'b0, 1'b0, 8'h08, 1'b1);
      d8(1'b0, 1'b0, 8'h00, 1'b1);
      d8(1'b0, 1'b1, 8'h80, 1'b0);
      d8(1'b0, 1'b1, 8'h80, 1'b1);
      d8(1'b0, 1'b1, 8'h00, 1'b1);
      d8(1'b0, 1'b1, 8'h00, 1'b1);

      // Asynchronous reset while a grant is held, then a full pass from line 0.
      d8(1'b0, 1'b1, 8'hFF, 1'b0);
      d8(1'b0, 1'b1, 8'hFF, 1'b0);
      d8(1'b1, 1'b1, 8'hFF, 1'b0);
      d8(1'b1, 1'b1, 8'hFF, 1'b0);
      repeat (11) d8(1'b0, 1'b1, 8'hFF, 1'b1);
      d8(1'b0, 1'b1, 8'h00, 1'b1);
      d8(1'b0, 1'b1, 8'h00, 1'b1);

      // WIDTH=16 with all lines requesting: two full passes and the start of a third.
      repeat (36) drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1);

      // Random traffic on both instances.
      for (int n = 0; n < 2000; n++) begin
         drive($urandom_range(0, 299) == 0, $urandom_range(0, 39) != 0,
               8'($urandom & $urandom), $urandom_range(0, 3) != 0,
               $urandom_range(0, 299) == 0, $urandom_range(0, 39) != 0,
               16'($urandom & $urandom & $urandom), $urandom_range(0, 3) != 0);
      end
      drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1);

      @(negedge clk_i);
      #1;
      if (q8.size() != 0 || q16.size() != 0) begin
         miscompares++;
         $display("FAIL drain: pending w8=%0d w16=%0d expected 0", q8.size(), q16.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
